// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable width/parity feeding a first-word-fall-through receive FIFO.
// Framing, parity and overrun errors are reported through sticky flags cleared by clr_err.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  input  logic                          clr_err,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [TW-1:0] TickMid  = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] TickLast = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 par_bad;
  logic                 push_req, frame_set, parity_set;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        count_q;
  logic                 push, pop, ovr_set;
  logic                 frame_err_q, parity_err_q, overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
    end
  end

  always_comb begin
    if (PARITY == 1)      par_bad = ~(^shift_q ^ par_q);
    else if (PARITY == 2) par_bad = ^shift_q ^ par_q;
    else                  par_bad = 1'b0;
  end

  // tick_q is forced to 0 on every state change so each state times from its own entry.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        tick_d = '0;
        bit_d  = '0;
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        if (tick_q == TickMid) begin
          tick_d  = '0;
          state_d = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BitLast) state_d = (PARITY != 0) ? StParity : StStop;
        end
      end
      StParity: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          par_d   = rxs_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick_q == TickLast) begin
          tick_d  = '0;
          state_d = StIdle;
          if (!rxs_q)       frame_set  = 1'b1;
          else if (par_bad) parity_set = 1'b1;
          else              push_req   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push    = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= frame_set  | (frame_err_q  & ~clr_err);
      parity_err_q <= parity_set | (parity_err_q & ~clr_err);
      overrun_q    <= ovr_set    | (overrun_q    & ~clr_err);
    end
  end

  assign rd_data    = empty ? '0 : mem_q[rptr_q];
  assign count      = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule
